// File: rtl/lbp_pkg.sv
// Shared defaults and FSM state encoding for the LBP 3x3 window fetch controller.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_IMG_H  = 128;
  localparam int LBP_ADDR_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } lbp_state_e;

endpackage

// File: rtl/lbp_fetch_ctrl_if.sv
// Gray-memory read port, datapath strobes and window handshake of the LBP fetch controller.
interface lbp_fetch_ctrl_if #(
  parameter int ADDR_W = 14
);

  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              shift_en;
  logic              cap_en;
  logic [1:0]        cap_row;
  logic              win_valid;
  logic              win_ready;
  logic [ADDR_W-1:0] center_addr;
  logic              finish;

  modport master (
    input  gray_ready, win_ready,
    output gray_req, gray_addr, shift_en, cap_en, cap_row,
           win_valid, center_addr, finish
  );

  modport slave (
    output gray_ready, win_ready,
    input  gray_req, gray_addr, shift_en, cap_en, cap_row,
           win_valid, center_addr, finish
  );

endinterface

// File: rtl/lbp_scan_cnt.sv
// Interior-centre scan counters: x runs 1..IMG_W-2 inside y 1..IMG_H-2, advancing once per accepted window.
module lbp_scan_cnt
  import lbp_pkg::*;
#(
  parameter int IMG_W  = LBP_IMG_W,
  parameter int IMG_H  = LBP_IMG_H,
  parameter int ADDR_W = LBP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] x_o,
  output logic [ADDR_W-1:0] y_o,
  output logic              row_last_o,
  output logic              last_pix_o
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv_i) begin
      if (x_q == X_LAST) begin
        x_d = ONE;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= ONE;
      y_q <= ONE;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign row_last_o = (x_q == X_LAST);
  assign last_pix_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/lbp_fetch_ctrl.sv
// Fetch controller: fills a 3x3 gray window column by column and hands each interior centre downstream.
// IMG_W*IMG_H must not exceed 2**ADDR_W.
module lbp_fetch_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W  = LBP_IMG_W,
  parameter int IMG_H  = LBP_IMG_H,
  parameter int ADDR_W = LBP_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  lbp_fetch_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  lbp_state_e        state_q;
  logic [1:0]        fill_q;
  logic [1:0]        row_q;
  logic [ADDR_W-1:0] x, y;
  logic              row_last, last_pix;
  logic              hs;
  logic [ADDR_W-1:0] rd_row, rd_col, rd_addr, ctr_addr;

  assign hs = (state_q == ST_EMIT) && bus.win_ready;

  lbp_scan_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_scan_cnt (
    .clk       (clk),
    .reset     (reset),
    .adv_i     (hs),
    .x_o       (x),
    .y_o       (y),
    .row_last_o(row_last),
    .last_pix_o(last_pix)
  );

  // fill_q counts columns still to load; the column being loaded is x+2-fill_q.
  assign rd_row   = y - ONE + ADDR_W'(row_q);
  assign rd_col   = x + ADDR_W'(2) - ADDR_W'(fill_q);
  assign rd_addr  = rd_row * W_A + rd_col;
  assign ctr_addr = y * W_A + x;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fill_q  <= 2'd3;
      row_q   <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.gray_ready) begin
            state_q <= ST_SHIFT;
            fill_q  <= 2'd3;
          end
        end
        ST_SHIFT: begin
          if (bus.gray_ready) begin
            state_q <= ST_LOAD;
            row_q   <= 2'd0;
          end
        end
        ST_LOAD: begin
          if (bus.gray_ready) begin
            if (row_q == 2'd2) begin
              row_q   <= 2'd0;
              fill_q  <= fill_q - 2'd1;
              state_q <= (fill_q == 2'd1) ? ST_EMIT : ST_SHIFT;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end
        end
        ST_EMIT: begin
          if (hs) begin
            if (last_pix) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
              fill_q  <= row_last ? 2'd3 : 2'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_DONE;
        default: begin
          state_q <= ST_IDLE;
          fill_q  <= 2'd3;
          row_q   <= 2'd0;
        end
      endcase
    end
  end

  // Strobes are gated by gray_ready in the same cycle so a stall never issues a read or shift.
  always_comb begin
    bus.gray_req    = 1'b0;
    bus.gray_addr   = '0;
    bus.shift_en    = 1'b0;
    bus.cap_en      = 1'b0;
    bus.cap_row     = 2'd0;
    bus.win_valid   = 1'b0;
    bus.center_addr = '0;
    bus.finish      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:  bus.finish = 1'b0;
        ST_SHIFT: bus.shift_en = bus.gray_ready;
        ST_LOAD: begin
          if (bus.gray_ready) begin
            bus.gray_req  = 1'b1;
            bus.cap_en    = 1'b1;
            bus.cap_row   = row_q;
            bus.gray_addr = rd_addr;
          end else begin
            bus.gray_req = 1'b0;
          end
        end
        ST_EMIT: begin
          bus.win_valid   = 1'b1;
          bus.center_addr = ctr_addr;
        end
        ST_DONE: bus.finish = 1'b1;
        default: bus.finish = 1'b0;
      endcase
    end else begin
      bus.finish = 1'b0;
    end
  end

endmodule

// File: tb/tb_lbp_fetch_ctrl.sv
// Self-checking bench for lbp_fetch_ctrl against a loop-generated read/centre schedule.
module tb_lbp_fetch_ctrl;

  localparam int W  = 128;
  localparam int H  = 6;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  lbp_fetch_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int errors = 0;
  int checks = 0;

  int exp_rd[$];
  int exp_row[$];
  int exp_ctr[$];
  int rd_grp, shift_cnt, hs_cnt, fin_seen;
  bit exp_fin, prev_valid, prev_ready;
  int prev_ctr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Every interior centre in raster order; the first centre of a row loads three columns, the rest one.
  task automatic build_model();
    exp_rd.delete();
    exp_row.delete();
    exp_ctr.delete();
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        int c0;
        c0 = (x == 1) ? 0 : x + 1;
        for (int c = c0; c <= x + 1; c++) begin
          for (int r = 0; r < 3; r++) begin
            exp_rd.push_back((y - 1 + r) * W + c);
            exp_row.push_back(r);
          end
        end
        exp_ctr.push_back(y * W + x);
      end
    end
    rd_grp = 0; shift_cnt = 0; hs_cnt = 0; fin_seen = 0;
    exp_fin = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_ctr = 0;
  endtask

  task automatic sample();
    logic hs;
    if (reset) begin
      check_eq("rst_outputs",
               {24'd0, bus.gray_req, bus.shift_en, bus.cap_en, bus.win_valid, bus.finish,
                |bus.gray_addr, |bus.center_addr, |bus.cap_row}, 32'd0);
      prev_valid = 1'b0;
      return;
    end
    check_eq("finish", {31'd0, bus.finish}, {31'd0, exp_fin});
    check_eq("shift_cap_excl", {31'd0, bus.shift_en & bus.cap_en}, 32'd0);
    check_eq("cap_eq_req", {31'd0, bus.cap_en}, {31'd0, bus.gray_req});
    if (!bus.gray_ready)
      check_eq("stall_quiet", {31'd0, bus.gray_req | bus.cap_en | bus.shift_en}, 32'd0);
    if (exp_fin)
      check_eq("done_quiet", {31'd0, bus.win_valid | bus.gray_req | bus.shift_en}, 32'd0);
    if (bus.gray_req) begin
      if (exp_rd.size() == 0) begin
        check_eq("rd_extra", 32'd1, 32'd0);
      end else begin
        if (exp_row[0] == 0) begin
          check_eq("shift_per_col", shift_cnt, rd_grp + 1);
          rd_grp++;
        end
        check_eq("rd_addr", {18'd0, bus.gray_addr}, exp_rd.pop_front());
        check_eq("cap_row", {30'd0, bus.cap_row}, exp_row.pop_front());
      end
    end
    if (bus.shift_en) shift_cnt++;
    if (prev_valid && !prev_ready) begin
      check_eq("hold_valid", {31'd0, bus.win_valid}, 32'd1);
      check_eq("hold_center", {18'd0, bus.center_addr}, prev_ctr);
    end
    hs = bus.win_valid & bus.win_ready;
    if (bus.win_valid) begin
      check_eq("emit_no_req", {31'd0, bus.gray_req}, 32'd0);
      if (exp_ctr.size() == 0) check_eq("ctr_extra", 32'd1, 32'd0);
      else check_eq("center_addr", {18'd0, bus.center_addr}, exp_ctr[0]);
    end
    if (hs && exp_ctr.size() != 0) begin
      void'(exp_ctr.pop_front());
      hs_cnt++;
      if (exp_ctr.size() == 0) exp_fin = 1'b1;
    end
    prev_valid = bus.win_valid;
    prev_ready = bus.win_ready;
    prev_ctr   = int'(bus.center_addr);
  endtask

  task automatic end_of_scan_checks();
    check_eq("hs_total", hs_cnt, (W - 2) * (H - 2));
    check_eq("shift_total", shift_cnt, W * (H - 2));
    check_eq("reads_left", exp_rd.size(), 0);
  endtask

  initial begin
    int  cyc, wr_hold, gr_hold;
    bit  did_w, did_g, did_r, rst_now;

    reset = 1'b1;
    bus.gray_ready = 1'b0;
    bus.win_ready  = 1'b0;
    build_model();
    repeat (3) begin
      @(negedge clk); #1; sample();
    end
    @(negedge clk);
    reset = 1'b0;
    #1; sample();

    // Directed run: one 5-cycle downstream stall and one 3-cycle memory stall at row 1.
    did_w = 1'b0; did_g = 1'b0; wr_hold = 0; gr_hold = 0; cyc = 0;
    while (!(exp_fin && fin_seen >= 3) && cyc < 20000) begin
      @(negedge clk);
      if (bus.win_valid && !did_w && hs_cnt == 1) begin
        wr_hold = 5;
        did_w = 1'b1;
      end
      bus.win_ready  = (wr_hold == 0);
      bus.gray_ready = (gr_hold == 0);
      if (wr_hold > 0) wr_hold--;
      if (gr_hold > 0) gr_hold--;
      #1; sample();
      if (!did_g && bus.gray_req && bus.cap_row == 2'd0 && rd_grp == 5) begin
        gr_hold = 3;
        did_g = 1'b1;
      end
      if (exp_fin) fin_seen++;
      cyc++;
    end
    if (cyc >= 20000) check_eq("timeout_directed", 32'd0, 32'd1);
    end_of_scan_checks();

    // Reset out of DONE, then a randomly stalled run with a reset pulse at centre 500.
    @(negedge clk);
    reset = 1'b1;
    #1; sample();
    build_model();
    @(negedge clk);
    reset = 1'b0;
    #1; sample();
    did_r = 1'b0; cyc = 0;
    while (!(exp_fin && fin_seen >= 3) && cyc < 40000) begin
      @(negedge clk);
      rst_now = !did_r && bus.win_valid && (bus.center_addr == 14'd500);
      reset = rst_now;
      bus.gray_ready = ($urandom_range(0, 3) != 0);
      bus.win_ready  = ($urandom_range(0, 3) != 0);
      #1; sample();
      if (rst_now) begin
        did_r = 1'b1;
        build_model();
      end
      if (exp_fin) fin_seen++;
      cyc++;
    end
    if (cyc >= 40000) check_eq("timeout_random", 32'd0, 32'd1);
    check_eq("reset_pulse_hit", {31'd0, did_r}, 32'd1);
    end_of_scan_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbp_fetch_ctrl.md
LBP_FETCH_CTRL -- requirements
Module: lbp_fetch_ctrl

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels.
REQ-002 Parameter IMG_H, default 128, image height in pixels.
REQ-003 Parameter ADDR_W, default 14, pixel address width; the block SHALL require IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 gray_ready  input  1  gray memory available; low SHALL pause fetching.
REQ-007 gray_req  output  1  read request to gray memory for the current cycle.
REQ-008 gray_addr  output  ADDR_W  read address; meaningful only while gray_req=1.
REQ-009 shift_en  output  1  one-cycle pulse; datapath shifts its 3x3 window one column left.
REQ-010 cap_en  output  1  datapath captures gray_data into window column 2 on this cycle's closing edge.
REQ-011 cap_row  output  2  window row (0..2) written by cap_en.
REQ-012 win_valid  output  1  window holds a complete 3x3 neighbourhood.
REQ-013 win_ready  input  1  downstream LBP core accepts the window.
REQ-014 center_addr  output  ADDR_W  linear address y*IMG_W+x of the window centre; stable while win_valid=1.
REQ-015 finish  output  1  whole interior scanned; remains high until reset.

Function
REQ-016 Scan order SHALL be interior centres only: y = 1..IMG_H-2 (outer loop), x = 1..IMG_W-2 (inner loop); border pixels SHALL NOT be emitted.
REQ-017 Read timing: gray_addr, gray_req, cap_en and cap_row SHALL be driven in the same cycle; gray memory returns data before the next rising edge, so the read latency is 0 extra cycles.
REQ-018 States: IDLE, SHIFT, LOAD, EMIT, DONE.
REQ-019 IDLE -> SHIFT when gray_ready=1; fill_cnt SHALL be set to 3 at the start of each row, and to 1 when advancing x.
REQ-020 SHIFT: shift_en=1 for exactly one cycle, then LOAD with row=0.
REQ-021 LOAD: for row r=0..2, the block SHALL assert gray_req=cap_en=1, cap_row=r, and gray_addr=(y-1+r)*IMG_W + (x+2-fill_cnt) with the fill_cnt value held at SHIFT entry; after r=2 it decrements fill_cnt and goes to SHIFT if fill_cnt is nonzero, else to EMIT.
REQ-022 EMIT: win_valid=1 and center_addr held stable until win_ready=1; the handshake completes on the edge where win_valid&win_ready.
REQ-023 On handshake: if x<IMG_W-2, then x++, fill_cnt=1, go to SHIFT.
REQ-024 On handshake with x=IMG_W-2 and y<IMG_H-2: x=1, y++, fill_cnt=3, go to SHIFT.
REQ-025 On handshake with x=IMG_W-2 and y=IMG_H-2: go to DONE.
REQ-026 DONE: finish=1; all request and strobe outputs 0; the block SHALL stay in DONE until reset.
REQ-027 gray_ready=0 in SHIFT or LOAD SHALL freeze state, counters and row index, and force gray_req=cap_en=shift_en=0; resume on return to 1 with no lost or duplicated read.
REQ-028 gray_ready does not affect EMIT; win_valid SHALL NOT drop without a handshake.
REQ-029 Address arithmetic SHALL be done at ADDR_W bits with no wrap for legal parameters.
REQ-030 At most one of shift_en and cap_en SHALL be high in any cycle.

Reset
REQ-031 reset=1 SHALL, on the next rising edge, force state IDLE, x=1, y=1, fill_cnt=3, row=0.
REQ-032 While reset=1, all outputs SHALL be 0, including finish, win_valid and center_addr.
REQ-033 Reset mid-operation, including in EMIT or DONE, SHALL abandon the scan; after release the scan restarts at (1,1) with a full 3-column fill.

Structure
REQ-034 Package lbp_pkg SHALL hold IMG_W, IMG_H, ADDR_W defaults and the state enumeration.
REQ-035 Sub-module lbp_scan_cnt SHALL hold the x/y counters with row-wrap and last-pixel flags; all other logic lives in lbp_fetch_ctrl.

Verification
REQ-036 Reset then gray_ready=1, win_ready=1: first reads SHALL be addr 0,128,256 (column 0), then 1,129,257 and 2,130,258; then win_valid with center_addr=129.
REQ-037 After the first accept: exactly one shift_en, then reads 3,131,259, then center_addr=130.
REQ-038 Row wrap: after accepting center_addr=254 (x=126), the next reads SHALL be 128,256,384, and the next center_addr=257.
REQ-039 win_ready held 0 for 5 cycles in EMIT: win_valid and center_addr stable, no gray_req; then exactly 126*126=15876 handshakes in total and finish=1 one cycle after the last handshake.
REQ-040 gray_ready dropped for 3 cycles mid-LOAD at row 1: the read sequence SHALL be identical to the uninterrupted run; shift_en never coincides with cap_en.
REQ-041 reset pulsed for 1 cycle in EMIT at center_addr=500: all outputs 0, finish=0; the restart issues reads 0,128,256 first.
